// File: rtl/led_pkg.sv
// Shared frame-buffer geometry, arbiter state encoding and a saturating counter helper.
package led_pkg;

  localparam int FB_ADDR_W = 6;
  localparam int FB_DATA_W = 24;
  localparam int ROW_SHIFT = 3;
  localparam int ROW_W     = FB_ADDR_W - ROW_SHIFT;
  localparam int STAT_W    = 16;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } arb_state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/arb_row_protect.sv
// Write eligibility for one requester: a valid write is held off while it targets the row being scanned out.
module arb_row_protect
  import led_pkg::*;
#(
  parameter int ADDR_W  = FB_ADDR_W,
  parameter int ROW_LSB = ROW_SHIFT
) (
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ROW_W-1:0]  scan_row,
  input  logic              scan_busy,
  output logic              eligible,
  output logic              blocked
);

  logic row_hit;

  assign row_hit  = scan_busy && ((addr >> ROW_LSB) == ADDR_W'(scan_row));
  assign eligible = valid && !row_hit;
  assign blocked  = valid && row_hit;

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter with bounded burst lock and scan-row protect for the frame-buffer write port.
// Define ARB_STATS_EN to add the stat_clr input and the stat_wr0/stat_wr1/stat_stall counters.
//
// state | meaning
// ARB   | round-robin between eligible requesters
// HOLD0 | req0 owns the port for a locked burst
// HOLD1 | req1 owns the port for a locked burst
module fb_write_arbiter
  import led_pkg::*;
#(
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int DATA_W   = FB_DATA_W,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_lock,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_lock,
  input  logic [ROW_W-1:0]  scan_row,
  input  logic              scan_busy,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              grant_id
`ifdef ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_wr0,
  output logic [STAT_W-1:0] stat_wr1,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam logic LOCK_EN = (MAX_HOLD > 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(MAX_HOLD - 1);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(MAX_HOLD);

  arb_state_t      state, state_nxt;
  logic [HC_W-1:0] hold_cnt, hold_nxt;
  logic            rr_ptr, rr_nxt;
  logic            elig0, elig1, blk0, blk1;

  arb_row_protect #(.ADDR_W(ADDR_W), .ROW_LSB(ADDR_W - ROW_W)) u_prot0 (
    .valid     (req0_valid),
    .addr      (req0_addr),
    .scan_row  (scan_row),
    .scan_busy (scan_busy),
    .eligible  (elig0),
    .blocked   (blk0)
  );

  arb_row_protect #(.ADDR_W(ADDR_W), .ROW_LSB(ADDR_W - ROW_W)) u_prot1 (
    .valid     (req1_valid),
    .addr      (req1_addr),
    .scan_row  (scan_row),
    .scan_busy (scan_busy),
    .eligible  (elig1),
    .blocked   (blk1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      hold_cnt <= '0;
      rr_ptr   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      rr_ptr   <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    rr_nxt     = rr_ptr;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      ARB: begin
        hold_nxt = '0;
        // A protected requester loses even when it holds round-robin priority.
        if (elig0 && (!elig1 || !rr_ptr)) begin
          req0_ready = 1'b1;
        end else if (elig1) begin
          req1_ready = 1'b1;
        end
        if (LOCK_EN && req0_ready && req0_lock) begin
          state_nxt = HOLD0;
          hold_nxt  = HC_W'(1);
        end else if (LOCK_EN && req1_ready && req1_lock) begin
          state_nxt = HOLD1;
          hold_nxt  = HC_W'(1);
        end
      end
      HOLD0: begin
        if (!req0_valid) begin
          state_nxt = ARB;
          hold_nxt  = '0;
        end else if (elig0) begin
          req0_ready = 1'b1;
          if (!req0_lock || hold_cnt >= HC_LAST) begin
            state_nxt = ARB;
            hold_nxt  = '0;
          end else if (hold_cnt != HC_MAX) begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
      end
      HOLD1: begin
        if (!req1_valid) begin
          state_nxt = ARB;
          hold_nxt  = '0;
        end else if (elig1) begin
          req1_ready = 1'b1;
          if (!req1_lock || hold_cnt >= HC_LAST) begin
            state_nxt = ARB;
            hold_nxt  = '0;
          end else if (hold_cnt != HC_MAX) begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ARB;
        hold_nxt  = '0;
      end
    endcase
    // Every grant hands priority to the other side, which also covers forced release.
    if (req0_ready) begin
      rr_nxt = 1'b1;
    end else if (req1_ready) begin
      rr_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      grant_id <= 1'b0;
    end else begin
      fb_we <= req0_ready || req1_ready;
      if (req0_ready) begin
        fb_addr  <= req0_addr;
        fb_data  <= req0_data;
        grant_id <= 1'b0;
      end else if (req1_ready) begin
        fb_addr  <= req1_addr;
        fb_data  <= req1_data;
        grant_id <= 1'b1;
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wr0   <= '0;
      stat_wr1   <= '0;
      stat_stall <= '0;
    end else if (stat_clr) begin
      stat_wr0   <= '0;
      stat_wr1   <= '0;
      stat_stall <= '0;
    end else begin
      if (req0_ready) stat_wr0 <= sat_inc(stat_wr0);
      if (req1_ready) stat_wr1 <= sat_inc(stat_wr1);
      if (blk0 || blk1) stat_stall <= sat_inc(stat_stall);
    end
  end
`else
  logic unused_blk;
  assign unused_blk = blk0 ^ blk1;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: table-driven round-robin/protect vectors plus burst, reset and stats sequences.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_lock;
  logic [5:0]  req0_addr;
  logic [23:0] req0_data;
  logic        req1_valid, req1_ready, req1_lock;
  logic [5:0]  req1_addr;
  logic [23:0] req1_data;
  logic [2:0]  scan_row;
  logic        scan_busy;
  logic        fb_we;
  logic [5:0]  fb_addr;
  logic [23:0] fb_data;
  logic        grant_id;
`ifdef ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_wr0, stat_wr1, stat_stall;
`endif

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_write_arbiter #(.ADDR_W(6), .DATA_W(24), .MAX_HOLD(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_lock  (req0_lock),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_lock  (req1_lock),
    .scan_row   (scan_row),
    .scan_busy  (scan_busy),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .grant_id   (grant_id)
`ifdef ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_wr0   (stat_wr0),
    .stat_wr1   (stat_wr1),
    .stat_stall (stat_stall)
`endif
  );

  typedef struct {
    logic       v0;
    logic [5:0] a0;
    logic       v1;
    logic [5:0] a1;
    logic [2:0] row;
    logic       busy;
    logic       r0;
    logic       r1;
    logic       we;
    logic [5:0] addr;
    logic       gid;
  } vec_t;

  vec_t vecs[13];
  logic exp_gid[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0; req0_lock = 1'b0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0; req1_lock = 1'b0;
    scan_row = '0; scan_busy = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
`ifdef ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    vecs[0]  = '{1'b1, 6'h01, 1'b1, 6'h09, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h01, 1'b0};
    vecs[1]  = '{1'b1, 6'h01, 1'b1, 6'h09, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h09, 1'b1};
    vecs[2]  = '{1'b1, 6'h01, 1'b1, 6'h09, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h01, 1'b0};
    vecs[3]  = '{1'b1, 6'h01, 1'b1, 6'h09, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h09, 1'b1};
    vecs[4]  = '{1'b0, 6'h01, 1'b1, 6'h09, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h09, 1'b1};
    vecs[5]  = '{1'b1, 6'h01, 1'b1, 6'h09, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h01, 1'b0};
    vecs[6]  = '{1'b1, 6'h1A, 1'b1, 6'h05, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 6'h05, 1'b1};
    vecs[7]  = '{1'b1, 6'h1A, 1'b1, 6'h05, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 6'h05, 1'b1};
    vecs[8]  = '{1'b1, 6'h1A, 1'b1, 6'h05, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h1A, 1'b0};
    vecs[9]  = '{1'b0, 6'h1A, 1'b0, 6'h05, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0};
    vecs[10] = '{1'b1, 6'h1F, 1'b1, 6'h18, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0};
    vecs[11] = '{1'b1, 6'h1F, 1'b1, 6'h18, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 6'h18, 1'b1};
    vecs[12] = '{1'b1, 6'h3F, 1'b0, 6'h18, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 6'h3F, 1'b0};

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Round robin and protect vectors, all starting from rr_ptr=0 in ARB.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      req0_valid = vecs[i].v0; req0_addr = vecs[i].a0; req0_data = 24'hA00000 | 24'(i);
      req1_valid = vecs[i].v1; req1_addr = vecs[i].a1; req1_data = 24'hB00000 | 24'(i);
      scan_row = vecs[i].row; scan_busy = vecs[i].busy;
      #1;
      check($sformatf("v%0d_req0_ready", i), 32'(req0_ready), 32'(vecs[i].r0));
      check($sformatf("v%0d_req1_ready", i), 32'(req1_ready), 32'(vecs[i].r1));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_fb_we", i), 32'(fb_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("v%0d_fb_addr", i), 32'(fb_addr), 32'(vecs[i].addr));
        check($sformatf("v%0d_grant_id", i), 32'(grant_id), 32'(vecs[i].gid));
        check($sformatf("v%0d_fb_data", i), 32'(fb_data),
              vecs[i].gid ? (32'hB00000 | 32'(i)) : (32'hA00000 | 32'(i)));
      end
    end

    // Lock burst: req0 first (rr_ptr=0), then 16 locked req1 beats, forced release to req0, req1 again.
    apply_reset();
    req0_valid = 1'b1; req0_addr = 6'h02; req0_data = 24'h000222; req0_lock = 1'b0;
    req1_valid = 1'b1; req1_addr = 6'h0B; req1_data = 24'h000BBB; req1_lock = 1'b1;
    exp_gid[0] = 1'b0;
    for (int k = 1; k <= 16; k++) exp_gid[k] = 1'b1;
    exp_gid[17] = 1'b0;
    exp_gid[18] = 1'b1;
    exp_gid[19] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("burst%0d_fb_we", k), 32'(fb_we), 32'd1);
      check($sformatf("burst%0d_grant_id", k), 32'(grant_id), 32'(exp_gid[k]));
    end

    // Reset asserted mid-burst clears fb_we without waiting for a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("midrst_fb_we", 32'(fb_we), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_req0_ready", 32'(req0_ready), 32'd1);
    check("postrst_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    check("postrst_fb_we", 32'(fb_we), 32'd1);
    check("postrst_grant_id", 32'(grant_id), 32'd0);
    check("postrst_fb_addr", 32'(fb_addr), 32'h02);

    // Locked req0 stalled by protect: no writes, req1 shut out, beat count frozen.
    apply_reset();
    req0_valid = 1'b1; req0_addr = 6'h2C; req0_data = 24'h00C0C0; req0_lock = 1'b1;
    req1_valid = 1'b1; req1_addr = 6'h03; req1_data = 24'h000303; req1_lock = 1'b0;
    @(posedge clk);
    #1;
    check("lp_first_fb_we", 32'(fb_we), 32'd1);
    check("lp_first_grant_id", 32'(grant_id), 32'd0);
    @(negedge clk);
    scan_row = 3'd5; scan_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("lp_stall%0d_req0_ready", k), 32'(req0_ready), 32'd0);
      check($sformatf("lp_stall%0d_req1_ready", k), 32'(req1_ready), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("lp_stall%0d_fb_we", k), 32'(fb_we), 32'd0);
      @(negedge clk);
    end
    scan_busy = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("lp_resume%0d_fb_we", k), 32'(fb_we), 32'd1);
      check($sformatf("lp_resume%0d_grant_id", k), 32'(grant_id), 32'd0);
    end
    @(posedge clk);
    #1;
    check("lp_release_fb_we", 32'(fb_we), 32'd1);
    check("lp_release_grant_id", 32'(grant_id), 32'd1);
    check("lp_release_fb_addr", 32'(fb_addr), 32'h03);

`ifdef ARB_STATS_EN
    // 7 protect stalls, 10 req0 writes, 5 req1 writes, then a clear.
    apply_reset();
    req0_valid = 1'b1; req0_addr = 6'h1A; req0_data = 24'h00001A;
    scan_row = 3'd3; scan_busy = 1'b1;
    repeat (7) @(negedge clk);
    scan_busy = 1'b0;
    repeat (10) @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 6'h05; req1_data = 24'h000005;
    repeat (5) @(negedge clk);
    req1_valid = 1'b0;
    #1;
    check("stat_wr0", 32'(stat_wr0), 32'd10);
    check("stat_wr1", 32'(stat_wr1), 32'd5);
    check("stat_stall", 32'(stat_stall), 32'd7);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    check("stat_wr0_clr", 32'(stat_wr0), 32'd0);
    check("stat_wr1_clr", 32'(stat_wr1), 32'd0);
    check("stat_stall_clr", 32'(stat_stall), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
